// File: rtl/cpu_bus_pkg.sv
// Shared CPU data-bus definitions: default bus widths and the arbiter state
// encoding, reused by the data-memory arbiter, the loader and the peripheral bridge.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // IDLE: CPU owns memory unless a loader grant fires; ACK: cycle after a loader access.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StAck  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears count
//   clr_i   : synchronous clear (dominates inc_i)
//   inc_i   : increment request, holds once MaxVal is reached
//   count_o : current count
module sat_counter #(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxVal = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxCnt)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage (default owner)
// and the UART bootloader/debug port. Loader accesses use idle CPU cycles, or
// force a one-cycle CPU stall once a request has waited MAX_WAIT cycles.
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   cpu_rd/cpu_wr       : MEM-stage read/write request
//   cpu_addr/cpu_wdata  : MEM-stage address and write data
//   cpu_rdata           : read data to MEM/WB (0 while the loader owns memory)
//   cpu_stall           : hold the MEM-stage access this cycle
//   ld_req/ld_we        : loader request and direction (1 = write)
//   ld_addr/ld_wdata    : loader address and write data
//   ld_ack              : one-cycle completion pulse
//   ld_rdata            : registered loader read data
//   mem_*               : data memory port (combinational read, write at clock edge)
module dmem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  bus_state_e state_q, state_d;
  logic [DATA_W-1:0] ld_rdata_q;
  logic [CntW-1:0] wait_cnt;
  logic cpu_busy;
  logic grant;
  logic cnt_clr;

  assign cpu_busy = cpu_rd | cpu_wr;

  // Grant only from IDLE, so the CPU can never be stalled two cycles in a row.
  always_comb begin
    grant   = 1'b0;
    state_d = StIdle;
    if (state_q == StIdle) begin
      grant   = ld_req && (!cpu_busy || (wait_cnt == MaxCnt));
      state_d = grant ? StAck : StIdle;
    end
  end

  always_comb begin
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    if (grant) begin
      mem_rd    = !ld_we;
      mem_wr    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      cpu_rdata = '0;
    end
  end

  assign cpu_stall = grant & cpu_busy;
  assign ld_ack    = (state_q == StAck);
  assign ld_rdata  = ld_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ld_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant && !ld_we) begin
        ld_rdata_q <= mem_rdata;
      end
    end
  end

  // Counts cycles a loader request waits; cleared on grant, in ACK and on abort.
  assign cnt_clr = !ld_req || grant || (state_q == StAck);

  sat_counter #(
    .Width (CntW),
    .MaxVal(MAX_WAIT)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .inc_i  (ld_req),
    .count_o(wait_cnt)
  );

endmodule
